// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - host-side load/control bundle for the 7-segment scan driver
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    lz_suppress;
  logic                    enable;

  modport master (
    output load, value, dp_in, blank_mask, lz_suppress, enable
  );

  modport slave (
    input load, value, dp_in, blank_mask, lz_suppress, enable
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 7-segment driver with dead time, zero blanking
// and tear-free frame-synchronous updates
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_scan_driver_if.slave     host,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done
);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0]         PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic                  SEG_LOW    = (SEG_ACTIVE_LOW != 0);
  localparam logic                  AN_LOW     = (AN_ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_OFF    = {7{SEG_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{AN_LOW}};

  // Glyphs in active-low abcdefg form; inverted below for active-high panels.
  function automatic logic [6:0] hex_code(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'h0:    c = 7'b1000000;
      4'h1:    c = 7'b1111001;
      4'h2:    c = 7'b0100100;
      4'h3:    c = 7'b0110000;
      4'h4:    c = 7'b0011001;
      4'h5:    c = 7'b0010010;
      4'h6:    c = 7'b0000010;
      4'h7:    c = 7'b1111000;
      4'h8:    c = 7'b0000000;
      4'h9:    c = 7'b0010000;
      4'hA:    c = 7'b0001000;
      4'hB:    c = 7'b0000011;
      4'hC:    c = 7'b1000110;
      4'hD:    c = 7'b0100001;
      4'hE:    c = 7'b0000110;
      default: c = 7'b0001110;
    endcase
    return c;
  endfunction

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d;
  logic                  pend_flag_q, pend_flag_d;
  logic [VW-1:0]         disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0] disp_blank_q, disp_blank_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic                  tick;
  logic                  wrap;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  cur_zero_above;
  logic [NUM_DIGITS-1:0] onehot;
  logic [NUM_DIGITS-1:0] zero_above;
  logic                  zero_run;
  logic                  in_dead;
  logic                  lz_dark;
  logic                  lit;

  // Scan timing and the pending/displayed register pair.
  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_flag_d  = pend_flag_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;

    tick = host.enable && (presc_q == PRESC_LAST);
    wrap = tick && (idx_q == IDX_LAST);

    if (host.enable) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + IW'(1);
    end

    // The old pending image is committed at the wrap; a load on that same
    // cycle re-arms the flag for the following frame.
    if (wrap && pend_flag_q) begin
      disp_val_d   = pend_val_q;
      disp_dp_d    = pend_dp_q;
      disp_blank_d = pend_blank_q;
      pend_flag_d  = 1'b0;
    end
    if (host.load) begin
      pend_val_d   = host.value;
      pend_dp_d    = host.dp_in;
      pend_blank_d = host.blank_mask;
      pend_flag_d  = 1'b1;
    end
  end

  // Per-slot digit selection and blanking decision.
  always_comb begin
    cur_nib        = 4'h0;
    cur_dp         = 1'b0;
    cur_blank      = 1'b0;
    cur_zero_above = 1'b0;
    onehot         = '0;
    zero_above     = '0;
    zero_run       = 1'b1;

    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run && (disp_val_q[4*i +: 4] == 4'h0);
      zero_above[i] = zero_run;
    end

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        onehot[i]      = 1'b1;
        cur_nib        = disp_val_q[4*i +: 4];
        cur_dp         = disp_dp_q[i];
        cur_blank      = disp_blank_q[i];
        cur_zero_above = zero_above[i];
      end
    end

    in_dead = (int'(presc_q) < DEAD_CYCLES);
    lz_dark = host.lz_suppress && (idx_q != '0) && cur_zero_above;
    lit     = host.enable && !in_dead && !cur_blank && !lz_dark;
  end

  always_comb begin
    seg_d        = SEG_OFF;
    dp_d         = SEG_LOW;
    an_d         = AN_OFF;
    frame_done_d = wrap;

    if (lit) begin
      seg_d = SEG_LOW ? hex_code(cur_nib) : ~hex_code(cur_nib);
      dp_d  = cur_dp ^ SEG_LOW;
      an_d  = onehot ^ AN_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_flag_q  <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= SEG_LOW;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_flag_q  <= pend_flag_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
// (4 digits, 4-cycle slots, 1 dead cycle, active-low)
module tb_seg7_scan_driver;
  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int FR  = N * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(DIV), .DEAD_CYCLES(1),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .host(bus),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference: position = count of enabled cycles since reset; slot and phase follow by division.
  int          p;
  logic [15:0] m_val, m_pval;
  logic [3:0]  m_dp, m_blank, m_pdp, m_pblank;
  logic        m_pflag;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_an;
  logic        exp_fd;

  int   m_slot, m_ph;
  logic m_dark, m_lit, m_eof;
  assign m_slot = (p / DIV) % N;
  assign m_ph   = p % DIV;
  assign m_dark = m_blank[m_slot] ||
                  (bus.lz_suppress && m_slot != 0 && (m_val >> (4 * m_slot)) == 16'd0);
  assign m_lit  = bus.enable && m_ph >= 1 && !m_dark;
  assign m_eof  = bus.enable && m_ph == DIV - 1 && m_slot == N - 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= 0; m_val <= '0; m_dp <= '0; m_blank <= '0;
      m_pval <= '0; m_pdp <= '0; m_pblank <= '0; m_pflag <= 1'b0;
      exp_seg <= 7'h7F; exp_dp <= 1'b1; exp_an <= 4'hF; exp_fd <= 1'b0;
    end else begin
      exp_seg <= m_lit ? glyph[m_val[4*m_slot +: 4]] : 7'h7F;
      exp_dp  <= !(m_lit && m_dp[m_slot]);
      exp_an  <= m_lit ? ~(4'b0001 << m_slot) : 4'hF;
      exp_fd  <= m_eof;
      if (m_eof && m_pflag) begin
        m_val <= m_pval; m_dp <= m_pdp; m_blank <= m_pblank;
      end
      if (bus.load) begin
        m_pval <= bus.value; m_pdp <= bus.dp_in; m_pblank <= bus.blank_mask;
      end
      m_pflag <= bus.load ? 1'b1 : (m_eof ? 1'b0 : m_pflag);
      if (bus.enable) p <= p + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pulse(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    bus.value = v; bus.dp_in = d; bus.blank_mask = b; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  // Leaves the bench just after the last cycle of a frame; the next step is slot 0, phase 0.
  task automatic wait_frame();
    int n = 0;
    do begin
      step();
      n++;
    end while (!exp_fd && n < 4 * FR);
    total++;
    if (!exp_fd) begin
      bad++;
      $display("FAIL wait_frame: no frame end within %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    bus.load = 0; bus.value = '0; bus.dp_in = '0; bus.blank_mask = '0;
    bus.lz_suppress = 0; bus.enable = 1;
    step(); step();
    total++;
    if ({seg, dp, an, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      bad++;
      $display("FAIL reset_hold: got seg=%b dp=%b an=%b fd=%b", seg, dp, an, frame_done);
    end
    rst_n = 1'b1;
    load_pulse(16'h8888, 4'hF, 4'h0);
    for (int i = 0; i < 2 * FR + 6; i++) begin
      step();
      total++;
      if ({seg, dp, an, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd}) begin
        bad++;
        $display("FAIL reset_prerun c%0d: got %b/%b/%b/%b exp %b/%b/%b/%b", i,
                 seg, dp, an, frame_done, exp_seg, exp_dp, exp_an, exp_fd);
      end
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({seg, dp, an, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      bad++;
      $display("FAIL reset_async: got seg=%b dp=%b an=%b fd=%b exp 1111111/1/1111/0",
               seg, dp, an, frame_done);
    end
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (an !== 4'hF) begin
      bad++;
      $display("FAIL reset_first_dead: an=%b exp 1111", an);
    end
    for (int i = 1; i < DIV; i++) begin
      step();
      total++;
      if (an !== 4'b1110 || seg !== 7'b1000000) begin
        bad++;
        $display("FAIL reset_digit0 ph%0d: an=%b seg=%b exp 1110/1000000", i, an, seg);
      end
    end
  endtask

  task automatic test_basic_scan();
    logic [6:0] want [4] = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
    load_pulse(16'h12AF, 4'h0, 4'h0);
    wait_frame();
    for (int k = 0; k < 2 * FR; k++) begin
      step();
      total++;
      if ((k % DIV) == 0) begin
        if (an !== 4'hF || seg !== 7'h7F) begin
          bad++;
          $display("FAIL scan_dead k%0d: an=%b seg=%b exp 1111/1111111", k, an, seg);
        end
      end else if (an !== ~(4'b0001 << ((k / DIV) % N)) || seg !== want[(k / DIV) % N] || dp !== 1'b1) begin
        bad++;
        $display("FAIL scan_slot k%0d: an=%b seg=%b dp=%b exp seg %b", k, an, seg, dp,
                 want[(k / DIV) % N]);
      end
      total++;
      if (frame_done !== ((k % FR) == FR - 1)) begin
        bad++;
        $display("FAIL scan_frame_done k%0d: got %b", k, frame_done);
      end
    end
  endtask

  task automatic test_tear_free();
    load_pulse(16'h1111, 4'h0, 4'h0);
    wait_frame();
    for (int k = 0; k < FR; k++) begin
      if (k == 5) load_pulse(16'h2222, 4'h0, 4'h0);
      else step();
      total++;
      if (k >= 2 * DIV && (k % DIV) != 0 && seg !== 7'b1111001) begin
        bad++;
        $display("FAIL tear_old k%0d: seg=%b exp 1111001", k, seg);
      end
    end
    for (int k = 0; k < FR; k++) begin
      if (k == 2) load_pulse(16'h2222, 4'h0, 4'h0);
      else if (k == 9) load_pulse(16'h3333, 4'h0, 4'h0);
      else step();
      total++;
      if ((k % DIV) != 0 && seg !== 7'b0100100) begin
        bad++;
        $display("FAIL tear_new k%0d: seg=%b exp 0100100", k, seg);
      end
    end
    for (int k = 0; k < FR; k++) begin
      step();
      total++;
      if (((k % DIV) != 0 && seg !== 7'b0110000) || seg === 7'b0100100) begin
        bad++;
        $display("FAIL tear_last_wins k%0d: seg=%b exp 0110000", k, seg);
      end
    end
  endtask

  task automatic test_lz();
    logic [3:0] want_an [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    logic [6:0] want_sg [4] = '{7'b1000000, 7'b0010010, 7'h7F, 7'h7F};
    bus.lz_suppress = 1'b1;
    load_pulse(16'h0050, 4'h0, 4'h0);
    wait_frame();
    for (int k = 0; k < FR; k++) begin
      step();
      if ((k % DIV) != 0) begin
        total++;
        if (an !== want_an[k / DIV] || seg !== want_sg[k / DIV]) begin
          bad++;
          $display("FAIL lz_0050 k%0d: an=%b seg=%b exp %b/%b", k, an, seg,
                   want_an[k / DIV], want_sg[k / DIV]);
        end
      end
    end
    load_pulse(16'h0000, 4'h0, 4'h0);
    wait_frame();
    for (int k = 0; k < FR; k++) begin
      step();
      total++;
      if ((k / DIV) == 0 && (k % DIV) != 0) begin
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
          bad++;
          $display("FAIL lz_zero_d0 k%0d: an=%b seg=%b exp 1110/1000000", k, an, seg);
        end
      end else if (an !== 4'hF) begin
        bad++;
        $display("FAIL lz_zero_dark k%0d: an=%b exp 1111", k, an);
      end
    end
    bus.lz_suppress = 1'b0;
  endtask

  task automatic test_dp_mask();
    load_pulse(16'($urandom), 4'b0100, 4'b0001);
    wait_frame();
    for (int k = 0; k < FR; k++) begin
      step();
      total++;
      if (dp !== !((k / DIV) == 2 && (k % DIV) != 0)) begin
        bad++;
        $display("FAIL dp_slot k%0d: dp=%b", k, dp);
      end
      total++;
      if (((k / DIV) == 0 && an !== 4'hF) || frame_done !== (k == FR - 1)) begin
        bad++;
        $display("FAIL mask_slot0 k%0d: an=%b fd=%b", k, an, frame_done);
      end
    end
  endtask

  task automatic test_enable();
    logic [3:0] resume [4] = '{4'b1101, 4'b1101, 4'b1111, 4'b1011};
    load_pulse(16'h4321, 4'h0, 4'h0);
    wait_frame();
    for (int k = 0; k < 6; k++) step();
    bus.enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (an !== 4'hF || seg !== 7'h7F || frame_done !== 1'b0) begin
        bad++;
        $display("FAIL enable_off c%0d: an=%b seg=%b fd=%b", i, an, seg, frame_done);
      end
    end
    bus.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (an !== resume[i]) begin
        bad++;
        $display("FAIL enable_resume c%0d: an=%b exp %b", i, an, resume[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bus.load        = ($urandom_range(0, 7) == 0);
      bus.value       = 16'($urandom);
      if ($urandom_range(0, 2) == 0) bus.value = bus.value & 16'h00FF;
      if ($urandom_range(0, 3) == 0) bus.value = bus.value & 16'h000F;
      bus.dp_in       = 4'($urandom);
      bus.blank_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      bus.enable      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) bus.lz_suppress = ~bus.lz_suppress;
      step();
      total++;
      if ({seg, dp, an, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd}) begin
        bad++;
        $display("FAIL random c%0d: got %b/%b/%b/%b exp %b/%b/%b/%b", i,
                 seg, dp, an, frame_done, exp_seg, exp_dp, exp_an, exp_fd);
      end
    end
    bus.load = 1'b0; bus.enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_lz();
    test_dp_mask();
    test_enable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
